// File: rtl/mem_access_stage.sv
// MEM pipeline stage: byte-addressable data memory with sized/sign-extended loads and lane stores.
// Optional debug memory dump streamer built only when MEM_DUMP_EN is defined.
module mem_access_stage #(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_ADDR = 6
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_mem_read,
    input  logic               i_mem_write,
    input  logic [2:0]         i_funct3,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic [NB_DATA-1:0] i_write_data,
    input  logic [1:0]         i_pipeline_mode,
    input  logic               i_execute_instruct,
    input  logic               i_dump_start,
    input  logic               i_dump_ready,
    output logic [NB_DATA-1:0] o_read_data,
    output logic               o_misaligned,
    output logic [NB_DATA-1:0] o_dump_data,
    output logic               o_dump_valid,
    output logic               o_dump_last,
    output logic               o_dump_busy
);

    localparam int Depth = 2 ** NB_ADDR;

    logic [NB_DATA-1:0] mem [Depth];

    logic [NB_ADDR-1:0] word_idx;
    logic [1:0]         byte_off;
    logic [4:0]         byte_sh;
    logic [4:0]         half_sh;
    logic [NB_DATA-1:0] rd_word;
    logic [NB_DATA-1:0] wr_word;
    logic [7:0]         rd_byte;
    logic [15:0]        rd_half;
    logic               is_half;
    logic               is_word;
    logic               misaligned;
    logic               store_code;
    logic               mode_ok;
    logic               store_en;
    logic               dump_busy;
    logic               unused_addr;

    // Upper address bits beyond the memory range are ignored, so addresses wrap.
    assign word_idx    = i_alu_result[NB_ADDR+1:2];
    assign byte_off    = i_alu_result[1:0];
    assign unused_addr = ^i_alu_result[NB_DATA-1:NB_ADDR+2];
    assign byte_sh     = {byte_off, 3'b000};
    assign half_sh     = {byte_off[1], 4'b0000};

    assign rd_word = mem[word_idx];
    assign rd_byte = rd_word[byte_sh +: 8];
    assign rd_half = rd_word[half_sh +: 16];

    assign is_half    = (i_funct3[1:0] == 2'b01);
    assign is_word    = (i_funct3 == 3'b010);
    assign misaligned = (i_mem_read | i_mem_write) &
                        ((is_half & byte_off[0]) | (is_word & (byte_off != 2'b00)));
    assign o_misaligned = misaligned;

    always_comb begin
        o_read_data = '0;
        if (i_mem_read && !misaligned) begin
            case (i_funct3)
                3'b000:  o_read_data = {{(NB_DATA-8){rd_byte[7]}}, rd_byte};
                3'b001:  o_read_data = {{(NB_DATA-16){rd_half[15]}}, rd_half};
                3'b010:  o_read_data = rd_word;
                3'b100:  o_read_data = {{(NB_DATA-8){1'b0}}, rd_byte};
                3'b101:  o_read_data = {{(NB_DATA-16){1'b0}}, rd_half};
                default: o_read_data = '0;
            endcase
        end
    end

    // Merge sub-word store data into the current word so untouched lanes are preserved.
    always_comb begin
        wr_word = rd_word;
        case (i_funct3)
            3'b000:  wr_word[byte_sh +: 8] = i_write_data[7:0];
            3'b001:  wr_word[half_sh +: 16] = i_write_data[15:0];
            default: wr_word = i_write_data;
        endcase
    end

    assign store_code = (i_funct3 == 3'b000) | (i_funct3 == 3'b001) | (i_funct3 == 3'b010);
    assign mode_ok    = (i_pipeline_mode == 2'b01) |
                        ((i_pipeline_mode == 2'b11) & i_execute_instruct);
    assign store_en   = i_mem_write & ~misaligned & store_code & ~dump_busy & mode_ok;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else if (store_en) begin
            mem[word_idx] <= wr_word;
        end
    end

`ifdef MEM_DUMP_EN
    typedef enum logic {StIdle, StSend} dump_state_e;

    dump_state_e        state;
    logic [NB_ADDR-1:0] dump_idx;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= StIdle;
            dump_idx <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (i_dump_start) begin
                        state    <= StSend;
                        dump_idx <= '0;
                    end
                end
                StSend: begin
                    if (i_dump_ready) begin
                        if (&dump_idx) begin
                            state <= StIdle;
                        end else begin
                            dump_idx <= dump_idx + 1'b1;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Stores are blocked while sending, so the addressed word stays stable under backpressure.
    assign dump_busy    = (state == StSend);
    assign o_dump_busy  = dump_busy;
    assign o_dump_valid = dump_busy;
    assign o_dump_last  = dump_busy & (&dump_idx);
    assign o_dump_data  = dump_busy ? mem[dump_idx] : '0;
`else
    logic unused_dump;

    assign unused_dump  = i_dump_start ^ i_dump_ready;
    assign dump_busy    = 1'b0;
    assign o_dump_busy  = 1'b0;
    assign o_dump_valid = 1'b0;
    assign o_dump_last  = 1'b0;
    assign o_dump_data  = '0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vector table, randomized model comparison, dump sequences.
module tb_mem_access_stage;

    logic        i_clk;
    logic        i_reset;
    logic        i_mem_read;
    logic        i_mem_write;
    logic [2:0]  i_funct3;
    logic [31:0] i_alu_result;
    logic [31:0] i_write_data;
    logic [1:0]  i_pipeline_mode;
    logic        i_execute_instruct;
    logic        i_dump_start;
    logic        i_dump_ready;
    logic [31:0] o_read_data;
    logic        o_misaligned;
    logic [31:0] o_dump_data;
    logic        o_dump_valid;
    logic        o_dump_last;
    logic        o_dump_busy;

    int checks   = 0;
    int failures = 0;

    logic [31:0] ref_mem [64];

    mem_access_stage dut (
        .i_clk              (i_clk),
        .i_reset            (i_reset),
        .i_mem_read         (i_mem_read),
        .i_mem_write        (i_mem_write),
        .i_funct3           (i_funct3),
        .i_alu_result       (i_alu_result),
        .i_write_data       (i_write_data),
        .i_pipeline_mode    (i_pipeline_mode),
        .i_execute_instruct (i_execute_instruct),
        .i_dump_start       (i_dump_start),
        .i_dump_ready       (i_dump_ready),
        .o_read_data        (o_read_data),
        .o_misaligned       (o_misaligned),
        .o_dump_data        (o_dump_data),
        .o_dump_valid       (o_dump_valid),
        .o_dump_last        (o_dump_last),
        .o_dump_busy        (o_dump_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  mode;
        logic        exec;
        logic [31:0] exp_rd;
        logic        exp_mis;
    } vec_t;

    vec_t tbl [27];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] mode, input logic exec);
        @(negedge i_clk);
        i_mem_read         = rd;
        i_mem_write        = wr;
        i_funct3           = f3;
        i_alu_result       = addr;
        i_write_data       = wdata;
        i_pipeline_mode    = mode;
        i_execute_instruct = exec;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 2'b01, 1'b0);
    endtask

    function automatic logic m_mis(logic rd, logic wr, logic [2:0] f3, logic [31:0] addr);
        if (!(rd || wr)) return 1'b0;
        if ((f3 == 3'd1 || f3 == 3'd5) && (addr % 2 != 0)) return 1'b1;
        if (f3 == 3'd2 && (addr % 4 != 0)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_load(logic rd, logic [2:0] f3, logic [31:0] addr);
        logic [31:0] w;
        logic [31:0] b;
        logic [31:0] h;
        w = ref_mem[(addr / 4) % 64];
        b = (w >> ((addr % 4) * 8)) & 32'hFF;
        h = (w >> (((addr % 4) / 2) * 16)) & 32'hFFFF;
        if (!rd || m_mis(rd, 1'b0, f3, addr)) return 32'h0;
        case (f3)
            3'd0:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            3'd1:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            3'd2:    return w;
            3'd4:    return b;
            3'd5:    return h;
            default: return 32'h0;
        endcase
    endfunction

    function automatic void m_store(logic wr, logic [2:0] f3, logic [31:0] addr,
                                    logic [31:0] data, logic [1:0] mode, logic exec,
                                    logic busy);
        int unsigned idx;
        int unsigned sh;
        idx = (addr / 4) % 64;
        if (!wr || m_mis(1'b0, wr, f3, addr) || busy) return;
        if (!(mode == 2'd1 || (mode == 2'd3 && exec))) return;
        case (f3)
            3'd0: begin
                sh = (addr % 4) * 8;
                ref_mem[idx] = (ref_mem[idx] & ~(32'hFF << sh)) | ((data & 32'hFF) << sh);
            end
            3'd1: begin
                sh = ((addr % 4) / 2) * 16;
                ref_mem[idx] = (ref_mem[idx] & ~(32'hFFFF << sh)) | ((data & 32'hFFFF) << sh);
            end
            3'd2:    ref_mem[idx] = data;
            default: ;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
    endtask

    initial begin
        logic        r_rd, r_wr, r_exec;
        logic [2:0]  r_f3;
        logic [1:0]  r_mode;
        logic [31:0] r_addr, r_data;

        i_reset = 1'b1;
        i_mem_read = 1'b0; i_mem_write = 1'b0; i_funct3 = 3'b000;
        i_alu_result = 32'h0; i_write_data = 32'h0; i_pipeline_mode = 2'b00;
        i_execute_instruct = 1'b0; i_dump_start = 1'b0; i_dump_ready = 1'b0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;

        tbl[0]  = '{1'b0, 1'b1, 3'b010, 32'h8,   32'h8000_00F0, 2'b01, 1'b0, 32'h0,         1'b0};
        tbl[1]  = '{1'b1, 1'b0, 3'b010, 32'h8,   32'h0,         2'b01, 1'b0, 32'h8000_00F0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 3'b000, 32'h9,   32'hFFFF_FF12, 2'b01, 1'b0, 32'h0,         1'b0};
        tbl[3]  = '{1'b1, 1'b0, 3'b000, 32'h9,   32'h0,         2'b01, 1'b0, 32'h0000_0012, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 3'b010, 32'h8,   32'h0,         2'b01, 1'b0, 32'h8000_12F0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 3'b001, 32'hA,   32'h0,         2'b01, 1'b0, 32'hFFFF_8000, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 3'b101, 32'hA,   32'h0,         2'b01, 1'b0, 32'h0000_8000, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 3'b010, 32'h4,   32'h1122_3344, 2'b01, 1'b0, 32'h0,         1'b0};
        tbl[8]  = '{1'b0, 1'b1, 3'b010, 32'h6,   32'hDEAD_BEEF, 2'b01, 1'b0, 32'h0,         1'b1};
        tbl[9]  = '{1'b1, 1'b0, 3'b010, 32'h4,   32'h0,         2'b01, 1'b0, 32'h1122_3344, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 3'b010, 32'h6,   32'h0,         2'b01, 1'b0, 32'h0,         1'b1};
        tbl[11] = '{1'b0, 1'b1, 3'b010, 32'h0,   32'h55,        2'b11, 1'b0, 32'h0,         1'b0};
        tbl[12] = '{1'b1, 1'b0, 3'b010, 32'h0,   32'h0,         2'b11, 1'b0, 32'h0,         1'b0};
        tbl[13] = '{1'b0, 1'b1, 3'b010, 32'h0,   32'h55,        2'b11, 1'b1, 32'h0,         1'b0};
        tbl[14] = '{1'b1, 1'b0, 3'b010, 32'h0,   32'h0,         2'b11, 1'b0, 32'h55,        1'b0};
        tbl[15] = '{1'b0, 1'b1, 3'b010, 32'h0,   32'h99,        2'b00, 1'b1, 32'h0,         1'b0};
        tbl[16] = '{1'b1, 1'b0, 3'b010, 32'h0,   32'h0,         2'b01, 1'b0, 32'h55,        1'b0};
        tbl[17] = '{1'b1, 1'b0, 3'b010, 32'h108, 32'h0,         2'b01, 1'b0, 32'h8000_12F0, 1'b0};
        tbl[18] = '{1'b1, 1'b0, 3'b000, 32'h8,   32'h0,         2'b01, 1'b0, 32'hFFFF_FFF0, 1'b0};
        tbl[19] = '{1'b1, 1'b0, 3'b100, 32'h8,   32'h0,         2'b01, 1'b0, 32'h0000_00F0, 1'b0};
        tbl[20] = '{1'b0, 1'b1, 3'b001, 32'hE,   32'h1234_BEEF, 2'b01, 1'b0, 32'h0,         1'b0};
        tbl[21] = '{1'b1, 1'b0, 3'b010, 32'hC,   32'h0,         2'b01, 1'b0, 32'hBEEF_0000, 1'b0};
        tbl[22] = '{1'b0, 1'b0, 3'b010, 32'h8,   32'h0,         2'b01, 1'b0, 32'h0,         1'b0};
        tbl[23] = '{1'b1, 1'b0, 3'b011, 32'h8,   32'h0,         2'b01, 1'b0, 32'h0,         1'b0};
        tbl[24] = '{1'b0, 1'b1, 3'b100, 32'hC,   32'hFF,        2'b01, 1'b0, 32'h0,         1'b0};
        tbl[25] = '{1'b1, 1'b0, 3'b010, 32'hC,   32'h0,         2'b01, 1'b0, 32'hBEEF_0000, 1'b0};
        tbl[26] = '{1'b0, 1'b0, 3'b001, 32'h1,   32'h0,         2'b01, 1'b0, 32'h0,         1'b0};

        // Reset state
        #1;
        check("reset_read_data", o_read_data, 32'h0);
        check("reset_misaligned", {31'h0, o_misaligned}, 32'h0);
        check("reset_dump_valid", {31'h0, o_dump_valid}, 32'h0);
        check("reset_dump_busy", {31'h0, o_dump_busy}, 32'h0);
        check("reset_dump_last", {31'h0, o_dump_last}, 32'h0);
        check("reset_dump_data", o_dump_data, 32'h0);
        @(negedge i_clk);
        i_reset = 1'b0;
        drive(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 2'b01, 1'b0);
        #1;
        check("post_reset_load", o_read_data, 32'h0);

        // Directed vector table
        for (int i = 0; i < 27; i++) begin
            drive(tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wdata,
                  tbl[i].mode, tbl[i].exec);
            #1;
            check($sformatf("tbl_read_data[%0d]", i), o_read_data, tbl[i].exp_rd);
            check($sformatf("tbl_misaligned[%0d]", i), {31'h0, o_misaligned},
                  {31'h0, tbl[i].exp_mis});
        end

        // Randomized ops against the reference model
        idle();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            r_rd   = 1'($urandom_range(0, 1));
            r_wr   = 1'($urandom_range(0, 1));
            r_f3   = 3'($urandom_range(0, 7));
            r_addr = $urandom();
            r_data = $urandom();
            r_mode = 2'($urandom_range(0, 3));
            r_exec = 1'($urandom_range(0, 1));
            drive(r_rd, r_wr, r_f3, r_addr, r_data, r_mode, r_exec);
            #1;
            check($sformatf("rand_read_data[%0d]", n), o_read_data, m_load(r_rd, r_f3, r_addr));
            check($sformatf("rand_misaligned[%0d]", n), {31'h0, o_misaligned},
                  {31'h0, m_mis(r_rd, r_wr, r_f3, r_addr)});
            m_store(r_wr, r_f3, r_addr, r_data, r_mode, r_exec, 1'b0);
        end
        // Sweep every word to catch corrupted lanes left by the random stores
        for (int i = 0; i < 64; i++) begin
            drive(1'b1, 1'b0, 3'b010, 32'(i * 4), 32'h0, 2'b01, 1'b0);
            #1;
            check($sformatf("sweep_word[%0d]", i), o_read_data, ref_mem[i]);
        end

`ifdef MEM_DUMP_EN
        begin
            int  exp_idx;
            bit  ready_t;
            bit  done;

            for (int i = 0; i < 64; i++) drive(1'b0, 1'b1, 3'b010, 32'(i * 4),
                                               32'hC0DE_0000 + 32'(i), 2'b01, 1'b0);
            idle();
            i_dump_start = 1'b1;
            exp_idx = 0; ready_t = 1'b1; done = 1'b0;
            for (int cyc = 0; cyc < 300 && !done; cyc++) begin
                @(negedge i_clk);
                i_dump_start = (cyc == 7);
                i_dump_ready = ready_t;
                i_mem_write  = (cyc == 5);
                i_funct3     = 3'b010;
                i_alu_result = 32'h0;
                i_write_data = 32'hFFFF_FFFF;
                #1;
                check("dump_valid", {31'h0, o_dump_valid}, 32'h1);
                check("dump_busy", {31'h0, o_dump_busy}, 32'h1);
                check($sformatf("dump_data[%0d]", exp_idx), o_dump_data,
                      32'hC0DE_0000 + 32'(exp_idx));
                check($sformatf("dump_last[%0d]", exp_idx), {31'h0, o_dump_last},
                      {31'h0, exp_idx == 63});
                @(posedge i_clk);
                if (ready_t) begin
                    if (exp_idx == 63) done = 1'b1;
                    else exp_idx++;
                end
                ready_t = ~ready_t;
            end
            check("dump_completed", {31'h0, done}, 32'h1);
            idle();
            i_dump_ready = 1'b0;
            #1;
            check("dump_idle_valid", {31'h0, o_dump_valid}, 32'h0);
            check("dump_idle_busy", {31'h0, o_dump_busy}, 32'h0);
            check("dump_idle_data", o_dump_data, 32'h0);
            drive(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 2'b01, 1'b0);
            #1;
            check("store_dropped_during_dump", o_read_data, 32'hC0DE_0000);

            // Reset at word 10 aborts the dump immediately
            idle();
            i_dump_start = 1'b1;
            @(negedge i_clk);
            i_dump_start = 1'b0;
            i_dump_ready = 1'b1;
            for (int k = 0; k < 10; k++) @(negedge i_clk);
            #1;
            check("dump_word10", o_dump_data, 32'hC0DE_000A);
            i_reset = 1'b1;
            i_mem_read = 1'b1; i_funct3 = 3'b010; i_alu_result = 32'h28;
            #1;
            check("abort_valid", {31'h0, o_dump_valid}, 32'h0);
            check("abort_busy", {31'h0, o_dump_busy}, 32'h0);
            check("abort_data", o_dump_data, 32'h0);
            check("abort_mem_cleared", o_read_data, 32'h0);
            @(negedge i_clk);
            i_reset = 1'b0;
            i_dump_ready = 1'b0;
            drive(1'b0, 1'b1, 3'b010, 32'h0, 32'h1, 2'b01, 1'b0);
            drive(1'b0, 1'b1, 3'b010, 32'h4, 32'h2, 2'b01, 1'b0);
            idle();
            i_dump_start = 1'b1;
            @(negedge i_clk);
            i_dump_start = 1'b0;
            i_dump_ready = 1'b1;
            #1;
            check("restart_word0", o_dump_data, 32'h1);
            check("restart_last0", {31'h0, o_dump_last}, 32'h0);
            @(negedge i_clk);
            #1;
            check("restart_word1", o_dump_data, 32'h2);
            done = 1'b0;
            for (int cyc = 0; cyc < 100 && !done; cyc++) begin
                @(negedge i_clk);
                #1;
                if (!o_dump_busy) done = 1'b1;
            end
            check("restart_finished", {31'h0, done}, 32'h1);
            i_dump_ready = 1'b0;
        end
`else
        // Without the dump feature the dump ports stay quiet and stores are never blocked
        drive(1'b0, 1'b1, 3'b010, 32'h10, 32'hA5A5_5A5A, 2'b01, 1'b0);
        i_dump_start = 1'b1;
        i_dump_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            i_dump_start = 1'b0;
            i_mem_write  = 1'b0;
            #1;
            check("nodump_valid", {31'h0, o_dump_valid}, 32'h0);
            check("nodump_busy", {31'h0, o_dump_busy}, 32'h0);
            check("nodump_last", {31'h0, o_dump_last}, 32'h0);
            check("nodump_data", o_dump_data, 32'h0);
        end
        drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 2'b01, 1'b0);
        #1;
        check("nodump_store_committed", o_read_data, 32'hA5A5_5A5A);
        i_dump_ready = 1'b0;
`endif

        idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
